// File: rtl/simple_circuit_pipe_if.sv
// Valid/ready bus carrying A/B/C/mode beats into the pipe and D/E results out of it.
// The slave view is the pipe itself; the master view is the surrounding producer/consumer.
interface simple_circuit_pipe_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic             mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] e;

  modport master (
    output in_valid, a, b, c, mode, out_ready,
    input  in_ready, out_valid, d, e
  );

  modport slave (
    input  in_valid, a, b, c, mode, out_ready,
    output in_ready, out_valid, d, e
  );
endinterface

// File: rtl/simple_circuit_pipe.sv
// Elastic valid/ready pipeline computing d = (a op b) | ~c and e = ~c, with a
// saturating counter of delivered beats whose d differs from the previous delivery.
module simple_circuit_pipe #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 3,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  simple_circuit_pipe_if.slave bus,
  input  logic                cnt_clr,
  output logic [CNT_W-1:0]    chg_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [STAGES-1:0] v;
  logic [WIDTH-1:0]  d_q [STAGES];
  logic [WIDTH-1:0]  e_q [STAGES];
  logic [STAGES-1:0] rdy_c;
  logic [WIDTH-1:0]  d0_c;
  logic [WIDTH-1:0]  e0_c;
  logic [WIDTH-1:0]  prev_d;
  logic              deliver_c;

  // Ready chain: a stage can load if it is empty or its successor can load.
  always_comb begin
    logic r;
    r     = bus.out_ready;
    rdy_c = '0;
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      r        = !v[k] || r;
      rdy_c[k] = r;
    end
  end

  assign d0_c = bus.mode ? ((bus.a ^ bus.b) | ~bus.c) : ((bus.a & bus.b) | ~bus.c);
  assign e0_c = ~bus.c;

  assign bus.in_ready  = rdy_c[0];
  assign bus.out_valid = v[STAGES-1];
  assign bus.d         = d_q[STAGES-1];
  assign bus.e         = e_q[STAGES-1];
  assign deliver_c     = v[STAGES-1] && bus.out_ready;

  // Pipeline stages; stage 0 captures the computed result, later stages only shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      v <= '0;
      for (int k = 0; k < int'(STAGES); k++) begin
        d_q[k] <= '0;
        e_q[k] <= '0;
      end
    end else begin
      if (rdy_c[0]) begin
        v[0]   <= bus.in_valid;
        d_q[0] <= d0_c;
        e_q[0] <= e0_c;
      end
      for (int k = 1; k < int'(STAGES); k++) begin
        if (rdy_c[k]) begin
          v[k]   <= v[k-1];
          d_q[k] <= d_q[k-1];
          e_q[k] <= e_q[k-1];
        end
      end
    end
  end

  // Change counter; clear wins over increment and leaves the last delivered d intact.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_d  <= '0;
      chg_cnt <= '0;
    end else begin
      if (deliver_c) begin
        prev_d <= d_q[STAGES-1];
      end
      if (cnt_clr) begin
        chg_cnt <= '0;
      end else if (deliver_c && (d_q[STAGES-1] != prev_d) && (chg_cnt != CNT_MAX)) begin
        chg_cnt <= chg_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_simple_circuit_pipe.sv
// Self-checking bench for simple_circuit_pipe: directed beats, backpressure, random
// traffic against a queue-based scoreboard, reset flush and counter saturation/clear.
module tb_simple_circuit_pipe;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned STAGES = 3;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned CNT_W2 = 2;
  localparam int          M_MAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  logic cnt_clr;
  logic cnt_clr2;
  logic [CNT_W-1:0]  chg_cnt;
  logic [CNT_W2-1:0] chg_cnt2;

  always #5 clk = ~clk;

  simple_circuit_pipe_if #(.WIDTH(WIDTH)) bus ();
  simple_circuit_pipe_if #(.WIDTH(WIDTH)) bus2 ();

  simple_circuit_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .bus(bus), .cnt_clr(cnt_clr), .chg_cnt(chg_cnt)
  );

  simple_circuit_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .CNT_W(CNT_W2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2), .cnt_clr(cnt_clr2), .chg_cnt(chg_cnt2)
  );

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [7:0] d;
    logic [7:0] e;
  } beat_t;

  beat_t      q[$];
  logic [7:0] m_prev;
  int         m_cnt;

  function automatic logic [7:0] ref_d(input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] c, input logic mode);
    return mode ? ((a ^ b) | ~c) : ((a & b) | ~c);
  endfunction

  // Update the reference model for the coming edge of dut, then move past that edge.
  task automatic advance();
    logic  acc;
    logic  dlv;
    beat_t nb;
    acc = bus.in_valid && bus.in_ready;
    dlv = bus.out_valid && bus.out_ready;
    if (rst) begin
      q.delete();
      m_prev = '0;
      m_cnt  = 0;
    end else begin
      if (dlv && q.size() > 0) begin
        if (cnt_clr) m_cnt = 0;
        else if (q[0].d != m_prev && m_cnt < M_MAX) m_cnt++;
        m_prev = q[0].d;
        void'(q.pop_front());
      end else if (cnt_clr) begin
        m_cnt = 0;
      end
      if (acc) begin
        nb.d = ref_d(bus.a, bus.b, bus.c, bus.mode);
        nb.e = ~bus.c;
        q.push_back(nb);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b1; bus.a = 8'h5A; bus.b = 8'hA5; bus.c = 8'h33; bus.mode = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    advance();
    advance();
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    tests++; if (bus.d !== 8'h00) begin fails++; $display("FAIL reset_d: got %h expected 00", bus.d); end
    tests++; if (bus.e !== 8'h00) begin fails++; $display("FAIL reset_e: got %h expected 00", bus.e); end
    tests++; if (chg_cnt !== '0) begin fails++; $display("FAIL reset_chg_cnt: got %0d expected 0", chg_cnt); end
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    tests++; if (chg_cnt2 !== '0 || bus2.out_valid !== 1'b0) begin fails++; $display("FAIL reset_dut2: got cnt %0d valid %b expected 0/0", chg_cnt2, bus2.out_valid); end
    rst = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      advance();
      tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_discard: got out_valid %b expected 0 at cycle %0d", bus.out_valid, i); end
    end
  endtask

  // One beat through an empty pipe with out_ready high; checks latency, data and counter.
  task automatic send_directed(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                               input logic mode, input logic [7:0] exp_d, input logic [7:0] exp_e,
                               input int exp_cnt, input string name);
    int n;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.a = a; bus.b = b; bus.c = c; bus.mode = mode;
    #1;
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL %s_in_ready: got %b expected 1", name, bus.in_ready); end
    advance();
    bus.in_valid = 1'b0;
    #1;
    n = 1;
    while (bus.out_valid !== 1'b1 && n < 10) begin
      advance();
      n++;
    end
    tests++; if (n != int'(STAGES)) begin fails++; $display("FAIL %s_latency: got %0d edges expected %0d", name, n, STAGES); end
    tests++; if (bus.d !== exp_d || bus.e !== exp_e) begin fails++; $display("FAIL %s_data: got d=%h e=%h expected d=%h e=%h", name, bus.d, bus.e, exp_d, exp_e); end
    advance();
    tests++; if (chg_cnt !== 16'(exp_cnt)) begin fails++; $display("FAIL %s_chg_cnt: got %0d expected %0d", name, chg_cnt, exp_cnt); end
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL %s_single: got out_valid %b expected 0", name, bus.out_valid); end
  endtask

  task automatic test_directed();
    send_directed(8'h00, 8'h00, 8'h00, 1'b0, 8'hFF, 8'hFF, 1, "zero");
    send_directed(8'hFF, 8'hFF, 8'hFF, 1'b0, 8'hFF, 8'h00, 1, "ones");
    send_directed(8'hF0, 8'hCC, 8'h0F, 1'b0, 8'hF0, 8'hF0, 2, "and_mode");
    send_directed(8'hF0, 8'hCC, 8'h0F, 1'b1, 8'hFC, 8'hF0, 3, "xor_mode");
  endtask

  task automatic test_backpressure();
    logic [7:0] hd;
    logic [7:0] he;
    int n;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.a = 8'($urandom); bus.b = 8'($urandom); bus.c = 8'($urandom); bus.mode = 1'($urandom);
      #1;
      tests++; if (bus.in_ready !== (i < 3)) begin fails++; $display("FAIL bp_in_ready_%0d: got %b expected %b", i, bus.in_ready, (i < 3)); end
      if (i < 3) advance();
    end
    tests++; if (bus.out_valid !== 1'b1 || bus.d !== q[0].d || bus.e !== q[0].e) begin fails++; $display("FAIL bp_head: got v=%b d=%h e=%h expected v=1 d=%h e=%h", bus.out_valid, bus.d, bus.e, q[0].d, q[0].e); end
    hd = bus.d;
    he = bus.e;
    for (int i = 0; i < 3; i++) begin
      advance();
      tests++; if (bus.out_valid !== 1'b1 || bus.d !== hd || bus.e !== he || bus.in_ready !== 1'b0) begin fails++; $display("FAIL bp_hold_%0d: got v=%b d=%h e=%h rdy=%b expected v=1 d=%h e=%h rdy=0", i, bus.out_valid, bus.d, bus.e, bus.in_ready, hd, he); end
    end
    bus.out_ready = 1'b1;
    #1;
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_in_ready: got %b expected 1", bus.in_ready); end
    n = 0;
    for (int cyc = 0; cyc < 20 && q.size() > 0; cyc++) begin
      if (bus.out_valid === 1'b1) begin
        tests++; if (bus.d !== q[0].d || bus.e !== q[0].e) begin fails++; $display("FAIL bp_order_%0d: got d=%h e=%h expected d=%h e=%h", n, bus.d, bus.e, q[0].d, q[0].e); end
        n++;
      end
      advance();
      bus.in_valid = 1'b0;
      #1;
    end
    tests++; if (n != 4 || q.size() != 0) begin fails++; $display("FAIL bp_count: got %0d delivered expected 4", n); end
  endtask

  task automatic test_random(input int nbeats);
    int   sent = 0;
    int   cyc = 0;
    logic pend = 1'b0;
    logic was_stall = 1'b0;
    logic [7:0] hd = '0;
    logic [7:0] he = '0;
    logic exp_rdy;
    while ((sent < nbeats || q.size() > 0) && cyc < 40000) begin
      if (!pend && sent < nbeats && $urandom_range(0, 3) != 0) begin
        bus.a = 8'($urandom); bus.b = 8'($urandom); bus.c = 8'($urandom); bus.mode = 1'($urandom);
        pend = 1'b1;
      end
      bus.in_valid  = pend;
      bus.out_ready = (sent >= nbeats) ? 1'b1 : ($urandom_range(0, 2) != 0);
      cnt_clr       = ($urandom_range(0, 63) == 0);
      #1;
      exp_rdy = (q.size() < int'(STAGES)) || bus.out_ready;
      tests++; if (bus.in_ready !== exp_rdy) begin fails++; $display("FAIL rnd_in_ready: got %b expected %b at cycle %0d", bus.in_ready, exp_rdy, cyc); end
      if (was_stall) begin
        tests++; if (bus.out_valid !== 1'b1 || bus.d !== hd || bus.e !== he) begin fails++; $display("FAIL rnd_stall_hold: got v=%b d=%h e=%h expected v=1 d=%h e=%h", bus.out_valid, bus.d, bus.e, hd, he); end
      end
      if (bus.out_valid === 1'b1) begin
        tests++;
        if (q.size() == 0) begin fails++; $display("FAIL rnd_extra_beat: got d=%h with no beat outstanding expected none", bus.d); end
        else if (bus.d !== q[0].d || bus.e !== q[0].e) begin fails++; $display("FAIL rnd_data: got d=%h e=%h expected d=%h e=%h", bus.d, bus.e, q[0].d, q[0].e); end
      end
      tests++; if (chg_cnt !== 16'(m_cnt)) begin fails++; $display("FAIL rnd_chg_cnt: got %0d expected %0d", chg_cnt, m_cnt); end
      was_stall = (bus.out_valid === 1'b1) && !bus.out_ready;
      hd = bus.d;
      he = bus.e;
      if (pend && bus.in_ready === 1'b1) begin
        pend = 1'b0;
        sent++;
      end
      advance();
      cyc++;
    end
    tests++; if (sent != nbeats || q.size() != 0) begin fails++; $display("FAIL rnd_complete: got %0d sent %0d outstanding expected %0d sent 0 outstanding", sent, q.size(), nbeats); end
    cnt_clr = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset_flush();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1; bus.a = 8'h00; bus.b = 8'h00; bus.c = 8'h00; bus.mode = 1'b0;
      #1;
      advance();
    end
    bus.in_valid = 1'b0;
    #1;
    advance();
    rst = 1'b1;
    bus.in_valid = 1'b1;
    #1;
    advance();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL flush_out_valid: got %b expected 0", bus.out_valid); end
    tests++; if (chg_cnt !== '0) begin fails++; $display("FAIL flush_chg_cnt: got %0d expected 0", chg_cnt); end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      advance();
      tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL flush_ghost_%0d: got out_valid %b expected 0", i, bus.out_valid); end
    end
  endtask

  // Single beat into dut2 (a=b=0, mode 0, so d = ~c), optionally clearing on its delivery.
  task automatic deliver2(input logic [7:0] cv, input logic clr, input logic [7:0] exp_d,
                          input int exp_cnt, input string name);
    int n;
    bus2.in_valid = 1'b1; bus2.a = 8'h00; bus2.b = 8'h00; bus2.c = cv; bus2.mode = 1'b0;
    #1;
    @(posedge clk); #1;
    bus2.in_valid = 1'b0;
    n = 0;
    while (bus2.out_valid !== 1'b1 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    tests++; if (bus2.out_valid !== 1'b1 || bus2.d !== exp_d) begin fails++; $display("FAIL %s_data: got v=%b d=%h expected v=1 d=%h", name, bus2.out_valid, bus2.d, exp_d); end
    cnt_clr2 = clr;
    #1;
    @(posedge clk); #1;
    cnt_clr2 = 1'b0;
    tests++; if (chg_cnt2 !== 2'(exp_cnt)) begin fails++; $display("FAIL %s_chg_cnt: got %0d expected %0d", name, chg_cnt2, exp_cnt); end
  endtask

  task automatic test_saturate();
    int dcount = 0;
    int exp;
    logic [7:0] exp_d;
    bus2.out_ready = 1'b1;
    for (int cyc = 0; cyc < 14; cyc++) begin
      if (cyc < 6) begin
        bus2.in_valid = 1'b1; bus2.a = 8'h00; bus2.b = 8'h00; bus2.mode = 1'b0;
        bus2.c = (cyc % 2 == 0) ? 8'h00 : 8'hFF;
      end else begin
        bus2.in_valid = 1'b0;
      end
      #1;
      exp = (dcount > 3) ? 3 : dcount;
      tests++; if (chg_cnt2 !== 2'(exp)) begin fails++; $display("FAIL sat_chg_cnt_%0d: got %0d expected %0d", cyc, chg_cnt2, exp); end
      if (bus2.out_valid === 1'b1) begin
        exp_d = (dcount % 2 == 0) ? 8'hFF : 8'h00;
        tests++; if (bus2.d !== exp_d) begin fails++; $display("FAIL sat_data_%0d: got %h expected %h", dcount, bus2.d, exp_d); end
        dcount++;
      end
      @(posedge clk); #1;
    end
    tests++; if (dcount != 6 || chg_cnt2 !== 2'd3) begin fails++; $display("FAIL sat_final: got %0d beats cnt %0d expected 6 beats cnt 3", dcount, chg_cnt2); end
    cnt_clr2 = 1'b1;
    #1;
    @(posedge clk); #1;
    cnt_clr2 = 1'b0;
    tests++; if (chg_cnt2 !== 2'd0) begin fails++; $display("FAIL clr_idle: got %0d expected 0", chg_cnt2); end
    deliver2(8'h00, 1'b1, 8'hFF, 0, "clr_on_delivery");
    deliver2(8'h00, 1'b0, 8'hFF, 0, "same_after_clr");
    deliver2(8'hFF, 1'b0, 8'h00, 1, "change_after_clr");
  endtask

  initial begin
    rst = 1'b1;
    cnt_clr = 1'b0;
    cnt_clr2 = 1'b0;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.c = '0; bus.mode = 1'b0; bus.out_ready = 1'b1;
    bus2.in_valid = 1'b0; bus2.a = '0; bus2.b = '0; bus2.c = '0; bus2.mode = 1'b0; bus2.out_ready = 1'b1;
    m_prev = '0;
    m_cnt = 0;
    test_reset();
    test_directed();
    test_backpressure();
    test_random(1000);
    test_reset_flush();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/simple_circuit_pipe.md
# simple_circuit_pipe

Parametrised, registered successor to the gate-level AND/OR/NOT circuit. The combinational delays become a configurable pipeline, and the circuit is widened to a WIDTH-bit vector with a selectable logic mode. Data moves through an elastic valid/ready pipeline with full backpressure. A saturating change counter tracks how often the delivered D output changes value. The block sits between a valid/ready producer of A/B/C vectors and a valid/ready consumer of D/E.

## Interface
- WIDTH, 8: bit width of each of a, b, c, d, e.
- STAGES, 3: pipeline depth, legal range 1..8.
- CNT_W, 16: width of the change counter.

- clk  in  1  rising-edge clock; the block's only clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat present.
- in_ready  out  1  block can accept a beat this cycle.
- a, b, c  in  WIDTH  operand vectors, sampled on accept.
- mode  in  1  sampled on accept. 0: d = (a & b) | ~c. 1: d = (a ^ b) | ~c.
- out_valid  out  1  output beat present.
- out_ready  in  1  consumer accepts the output beat.
- d, e  out  WIDTH  results; e = ~c in both modes.
- cnt_clr  in  1  synchronous clear of chg_cnt.
- chg_cnt  out  CNT_W  number of delivered beats whose d differed from the previously delivered d.

## Operation
- An input beat is accepted when in_valid && in_ready.
- d and e are computed combinationally from a, b, c and mode at stage 0 and written into stage 0. Stages 1..STAGES-1 only move data.
- Each stage k holds {v[k], d[k], e[k]}. rdy[STAGES] = out_ready. rdy[k] = !v[k] || rdy[k+1]. in_ready = rdy[0].
- Stage k loads when rdy[k] is high:
  - from the upstream stage, taking v[k-1] and its data;
  - stage 0 loads from the input, taking v = in_valid && in_ready.
- When rdy[k] is low, stage k holds its contents.
- Bubbles collapse. Beats are never dropped or duplicated, and order is preserved.
- Outputs: out_valid = v[STAGES-1]; d and e come from the last stage.
- d and e must stay stable while out_valid && !out_ready.
- Change counter:
  - prev_d is updated with d on every delivered beat (out_valid && out_ready).
  - chg_cnt increments when a delivered d != prev_d.
  - chg_cnt saturates at 2^CNT_W - 1.
  - cnt_clr has priority over increment.
  - cnt_clr does not alter prev_d.

## Timing
- Reset values: all v = 0, all stage d/e = 0, out_valid = 0, d = 0, e = 0, prev_d = 0, chg_cnt = 0.
- in_ready during reset follows rdy[0] (= 1 with every stage empty). Beats presented while rst = 1 are discarded.
- Reset mid-operation flushes every in-flight beat the following cycle. No partial output appears.
- Latency: a beat accepted at edge N appears with out_valid = 1 after edge N+STAGES-1, i.e. STAGES cycles after it is presented, with no stalls.
- Throughput: 1 beat/cycle while out_ready = 1.
- Capacity: at most STAGES beats in flight. With out_ready = 0 and all stages full, in_ready = 0.
- Simultaneous events:
  - With a full pipe, an output delivery and an input accept can happen in the same cycle; in_ready is combinationally high through the rdy chain.
  - cnt_clr on a delivery cycle leaves chg_cnt = 0, not 1.
- in_ready depends combinationally on out_ready through at most STAGES levels. No other combinational input-to-output path exists.
- mode is latched per beat. Changing mode does not affect beats already in flight.

## Test plan
- Reset then A=B=C=8'h00, mode 0, single beat, out_ready = 1: d = 8'hFF and e = 8'hFF appear exactly 3 cycles after presentation. chg_cnt = 1.
- Next beat A=B=C=8'hFF: d = 8'hFF, e = 8'h00, chg_cnt stays 1. Then A=8'hF0, B=8'hCC, C=8'h0F: mode 0 gives d = 8'hF0 (chg_cnt = 2), mode 1 on the following beat gives d = 8'hFC (chg_cnt = 3). e = 8'hF0 for both.
- Backpressure: out_ready = 0, present 4 back-to-back beats. The first 3 are accepted and in_ready drops. Release out_ready: all 4 beats are delivered in order. d/e are held stable during the stall.
- Random in_valid/out_ready toggling over 1000 beats, compared against a scoreboard: no loss, no duplication, order preserved, every d/e correct.
- Assert rst with 2 beats in flight: out_valid = 0 the next cycle, those beats never appear, chg_cnt = 0.
- CNT_W = 2, alternate d between 8'h00 and 8'hFF for 6 beats: chg_cnt saturates at 3. cnt_clr asserted on a delivery cycle gives chg_cnt = 0.
